// File: rtl/excp_ctrl.sv
// rtl/excp_ctrl.sv - commit-stage trap/ERET controller: strobes cp0, flushes the pipe, redirects fetch
module excp_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_slot,
    input  logic        m_excp,
    input  logic        m_is_eret,
    input  logic        stall,
    input  logic        is_int,
    input  logic [31:0] entrance,
    input  logic [31:0] epc,
    input  logic        redirect_ready,
    output logic        ctype_exc,
    output logic [31:0] pc_o,
    output logic        is_slot_o,
    output logic        inter_valid,
    output logic [31:0] int_pc,
    output logic        int_slot,
    output logic        is_eret_o,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    // Low from reset until the first rising edge after release, so no event
    // can be taken in the cycle reset deasserts.
    logic        r_armed;
    logic        w_event;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_target <= 32'd0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_armed  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_target_nxt   = r_target;
        ctype_exc      = 1'b0;
        pc_o           = 32'd0;
        is_slot_o      = 1'b0;
        inter_valid    = 1'b0;
        int_pc         = 32'd0;
        int_slot       = 1'b0;
        is_eret_o      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset gating keeps the combinational strobes quiet while reset is held.
        w_event = reset && r_armed && (r_state == S_IDLE) && m_valid && !stall
                  && (is_int || m_excp || m_is_eret);

        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = LP_CNT_INIT;
                    if (is_int) begin
                        inter_valid  = 1'b1;
                        int_pc       = m_pc;
                        int_slot     = m_is_slot;
                        w_target_nxt = entrance;
                    end else if (m_excp) begin
                        ctype_exc    = 1'b1;
                        pc_o         = m_pc;
                        is_slot_o    = m_is_slot;
                        w_target_nxt = entrance;
                    end else begin
                        is_eret_o    = 1'b1;
                        w_target_nxt = epc;
                    end
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_REDIRECT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// tb/tb_excp_ctrl.sv - directed self-checking bench for excp_ctrl
module tb_excp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_is_slot;
    logic        m_excp;
    logic        m_is_eret;
    logic        stall;
    logic        is_int;
    logic [31:0] entrance;
    logic [31:0] epc;
    logic        redirect_ready;
    logic        ctype_exc;
    logic [31:0] pc_o;
    logic        is_slot_o;
    logic        inter_valid;
    logic [31:0] int_pc;
    logic        int_slot;
    logic        is_eret_o;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    logic [102:0] w_all;
    assign w_all = {ctype_exc, pc_o, is_slot_o, inter_valid, int_pc, int_slot,
                    is_eret_o, flush, redirect_valid, redirect_pc};

    excp_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_valid        (m_valid),
        .m_pc           (m_pc),
        .m_is_slot      (m_is_slot),
        .m_excp         (m_excp),
        .m_is_eret      (m_is_eret),
        .stall          (stall),
        .is_int         (is_int),
        .entrance       (entrance),
        .epc            (epc),
        .redirect_ready (redirect_ready),
        .ctype_exc      (ctype_exc),
        .pc_o           (pc_o),
        .is_slot_o      (is_slot_o),
        .inter_valid    (inter_valid),
        .int_pc         (int_pc),
        .int_slot       (int_slot),
        .is_eret_o      (is_eret_o),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_valid        = 1'b0;
        m_pc           = 32'd0;
        m_is_slot      = 1'b0;
        m_excp         = 1'b0;
        m_is_eret      = 1'b0;
        stall          = 1'b0;
        is_int         = 1'b0;
        redirect_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        entrance = 32'd0;
        epc      = 32'd0;
        clear_inputs();
        #2;
        chk("reset_all_zero", 128'(w_all), 128'd0);
        m_valid = 1'b1;
        is_int  = 1'b1;
        #1;
        chk("reset_int_blocked", 128'(inter_valid), 128'd0);

        // release mid-cycle; the pending interrupt must not fire before the next edge
        #14;
        reset = 1'b1;
        #1;
        chk("post_reset_all_zero", 128'(w_all), 128'd0);
        clear_inputs();
        tick();

        // exception in a delay slot
        m_valid   = 1'b1;
        m_excp    = 1'b1;
        m_pc      = 32'h8000_1000;
        m_is_slot = 1'b1;
        entrance  = 32'hBFC0_0380;
        #1;
        chk("exc_strobe", 128'(ctype_exc), 128'd1);
        chk("exc_pc", 128'(pc_o), 128'h8000_1000);
        chk("exc_slot", 128'(is_slot_o), 128'd1);
        chk("exc_no_int", 128'(inter_valid), 128'd0);
        chk("exc_idle_noflush", 128'(flush), 128'd0);
        tick();
        clear_inputs();
        m_valid  = 1'b1;
        is_int   = 1'b1;
        entrance = 32'h1234_5678;
        #1;
        chk("flush1", 128'(flush), 128'd1);
        chk("flush1_ignore_int", 128'(inter_valid), 128'd0);
        chk("flush1_no_redirect", 128'(redirect_valid), 128'd0);
        tick();
        chk("flush2", 128'(flush), 128'd1);
        chk("flush2_no_redirect", 128'(redirect_valid), 128'd0);
        clear_inputs();
        tick();
        chk("exc_redirect_valid", 128'(redirect_valid), 128'd1);
        chk("exc_redirect_pc", 128'(redirect_pc), 128'hBFC0_0380);
        chk("exc_redirect_flush", 128'(flush), 128'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("exc_back_idle", 128'({flush, redirect_valid}), 128'd0);

        // interrupt beats exception; then backpressure on the redirect
        m_valid  = 1'b1;
        is_int   = 1'b1;
        m_excp   = 1'b1;
        m_pc     = 32'h8000_2004;
        entrance = 32'hBFC0_0380;
        #1;
        chk("int_strobe", 128'(inter_valid), 128'd1);
        chk("int_pc", 128'(int_pc), 128'h8000_2004);
        chk("int_slot", 128'(int_slot), 128'd0);
        chk("int_no_exc", 128'(ctype_exc), 128'd0);
        chk("int_pc_o_zero", 128'(pc_o), 128'd0);
        tick();
        clear_inputs();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 128'(redirect_valid), 128'd1);
            chk("bp_pc", 128'(redirect_pc), 128'hBFC0_0380);
            tick();
        end
        chk("bp_still_valid", 128'(redirect_valid), 128'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("bp_back_idle", 128'({flush, redirect_valid}), 128'd0);

        // ERET
        m_valid   = 1'b1;
        m_is_eret = 1'b1;
        epc       = 32'h8000_3000;
        entrance  = 32'hDEAD_BEEF;
        #1;
        chk("eret_strobe", 128'(is_eret_o), 128'd1);
        chk("eret_no_other", 128'({ctype_exc, inter_valid}), 128'd0);
        tick();
        clear_inputs();
        tick();
        tick();
        chk("eret_redirect_pc", 128'(redirect_pc), 128'h8000_3000);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // m_valid low masks the exception
        m_excp = 1'b1;
        #1;
        chk("novalid_no_exc", 128'(ctype_exc), 128'd0);
        tick();
        chk("novalid_no_flush", 128'(flush), 128'd0);
        clear_inputs();

        // stall defers the interrupt
        m_valid = 1'b1;
        is_int  = 1'b1;
        stall   = 1'b1;
        m_pc    = 32'h8000_4000;
        #1;
        chk("stall1_no_int", 128'(inter_valid), 128'd0);
        tick();
        chk("stall2_no_int", 128'(inter_valid), 128'd0);
        chk("stall2_no_flush", 128'(flush), 128'd0);
        tick();
        stall = 1'b0;
        #1;
        chk("unstall_int", 128'(inter_valid), 128'd1);
        chk("unstall_int_pc", 128'(int_pc), 128'h8000_4000);
        tick();
        clear_inputs();
        chk("stall_flush", 128'(flush), 128'd1);

        // reset in the middle of the flush
        reset = 1'b0;
        #1;
        chk("rst_mid_all_zero", 128'(w_all), 128'd0);
        tick();
        #3;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_redirect", 128'({flush, redirect_valid}), 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
